// File: rtl/mem2_pkg.sv
// Shared constants and types for the mem2 scratch RAM.
// Default geometry is 64 words of 8 bits, but only a 4-bit address, so words 0..15 are reachable.
package mem2_pkg;

    localparam int MEM2_DATA_WIDTH = 8;
    localparam int MEM2_MEM_SIZE   = 64;
    localparam int MEM2_ADDR_WIDTH = 4;

    typedef logic [MEM2_DATA_WIDTH-1:0] mem2_data_t;
    typedef logic [MEM2_ADDR_WIDTH-1:0] mem2_addr_t;

    // Index width of an array of 'size' words; a single-word array still needs one bit.
    function automatic int mem2_idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/mem2_storage.sv
// Bare storage array for mem2_ram.
// Synchronous write port, combinational read index; range checking is done by the caller.
module mem2_storage #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    // NOTE: the array has no reset so it can map onto RAM macros; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mem2_ram.sv
// Simple-dual-port RAM with a registered, asynchronously reset read port.
// Define MEM2_WRITE_FIRST_EN to forward same-address write data to the read port (write-first).
module mem2_ram
    import mem2_pkg::*;
#(
    parameter int DATA_WIDTH = MEM2_DATA_WIDTH,
    parameter int MEM_SIZE   = MEM2_MEM_SIZE,
    parameter int ADDR_WIDTH = MEM2_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = mem2_idx_width(MEM_SIZE);

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_en_eff;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;

    assign wr_in_range = (32'(write_address) < 32'(MEM_SIZE));
    assign rd_in_range = (32'(read_address)  < 32'(MEM_SIZE));
    assign wr_idx      = IDX_W'(write_address);
    assign rd_idx      = IDX_W'(read_address);

    // The array has no reset of its own, so writes must be blocked explicitly while rst is high.
    assign wr_en_eff = write_en & wr_in_range & ~rst;

    mem2_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .IDX_W      (IDX_W)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (wr_en_eff),
        .wr_idx_i  (wr_idx),
        .wr_data_i (data_in),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

`ifdef MEM2_WRITE_FIRST_EN
    assign fwd = write_en & wr_in_range & (write_address == read_address);
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
        data_out_d = '0;
        if (rd_in_range) begin
            data_out_d = fwd ? data_in : rd_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (read_en) begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_mem2_ram.sv
// Self-checking bench for mem2_ram: directed vector table, reset sequences, and random
// traffic against an array model; a second 10-word instance exercises out-of-range addresses.
module tb_mem2_ram;
    import mem2_pkg::*;

    localparam int SMALL_SIZE = 10;
`ifdef MEM2_WRITE_FIRST_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en;
    mem2_addr_t write_address;
    mem2_data_t data_in;
    logic       read_en;
    mem2_addr_t read_address;
    mem2_data_t data_out;
    mem2_data_t data_out_small;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem2_ram dut (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .write_address (write_address),
        .data_in       (data_in),
        .read_en       (read_en),
        .read_address  (read_address),
        .data_out      (data_out)
    );

    mem2_ram #(.MEM_SIZE(SMALL_SIZE)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .write_address (write_address),
        .data_in       (data_in),
        .read_en       (read_en),
        .read_address  (read_address),
        .data_out      (data_out_small)
    );

    typedef struct {
        logic       we;
        mem2_addr_t wa;
        mem2_data_t din;
        logic       re;
        mem2_addr_t ra;
        mem2_data_t exp;
    } vec_t;

    vec_t vecs[12];

    mem2_data_t ref_big   [16];
    mem2_data_t ref_small [SMALL_SIZE];
    mem2_data_t exp_big;
    mem2_data_t exp_small;

    task automatic check(input string name, input mem2_data_t actual, input mem2_data_t expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and return just after the next rising edge.
    task automatic step(input logic we, input mem2_addr_t wa, input mem2_data_t din,
                        input logic re, input mem2_addr_t ra);
        @(negedge clk);
        write_en      = we;
        write_address = wa;
        data_in       = din;
        read_en       = re;
        read_address  = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed sequence; expected data_out just after each edge.
        vecs[0]  = '{1'b1, 4'd0, 8'h11, 1'b0, 4'd0, 8'h00};
        vecs[1]  = '{1'b1, 4'd1, 8'h22, 1'b0, 4'd0, 8'h00};
        vecs[2]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'h11};
        vecs[3]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 8'h22};
        vecs[4]  = '{1'b1, 4'd1, 8'hA5, 1'b0, 4'd1, 8'h22};
        vecs[5]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 8'hA5};
        vecs[6]  = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'hA5};
        vecs[7]  = '{1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'hA5};
        vecs[8]  = '{1'b1, 4'd3, 8'hC3, 1'b1, 4'd3, WRITE_FIRST ? 8'hC3 : 8'h5A};
        vecs[9]  = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'hC3};
        vecs[10] = '{1'b1, 4'd4, 8'h99, 1'b1, 4'd0, 8'h11};
        vecs[11] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h99};

        // Power-up reset with a read strobe active.
        rst = 1'b1; write_en = 1'b0; write_address = '0; data_in = '0;
        read_en = 1'b1; read_address = '0;
        #1;
        check("reset_immediate", data_out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        read_en = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].din, vecs[i].re, vecs[i].ra);
            check($sformatf("vec%0d", i), data_out, vecs[i].exp);
        end

        // Mid-operation reset: output clears asynchronously, accesses are ignored, contents kept.
        @(negedge clk);
        write_en = 1'b1; write_address = 4'd0; data_in = 8'hFF;
        read_en = 1'b1; read_address = 4'd4;
        rst = 1'b1;
        #1;
        check("midreset_async", data_out, 8'h00);
        check("midreset_async_small", data_out_small, 8'h00);
        @(posedge clk);
        #1;
        check("midreset_held", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
        check("midreset_retained", data_out, 8'h11);
        check("midreset_retained_small", data_out_small, 8'h11);

        // Fill every reachable word so the model and both DUTs agree on all contents.
        for (int a = 0; a < 16; a++) begin
            mem2_data_t v;
            v = 8'($urandom);
            step(1'b1, 4'(a), v, 1'b0, 4'd0);
            ref_big[a] = v;
            if (a < SMALL_SIZE) ref_small[a] = v;
        end
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
        exp_big   = ref_big[0];
        exp_small = ref_small[0];
        check("fill_read0", data_out, exp_big);
        check("fill_read0_small", data_out_small, exp_small);

        // Random traffic: reads see pre-edge contents unless write-first forwarding applies.
        for (int n = 0; n < 400; n++) begin
            logic       we, re, hit;
            mem2_addr_t wa, ra;
            mem2_data_t din;
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            wa  = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            din = 8'($urandom);
            hit = we && (wa == ra) && WRITE_FIRST;
            if (re) begin
                exp_big   = hit ? din : ref_big[ra];
                exp_small = (int'(ra) >= SMALL_SIZE) ? 8'h00 : (hit ? din : ref_small[ra]);
            end
            if (we) begin
                ref_big[wa] = din;
                if (int'(wa) < SMALL_SIZE) ref_small[wa] = din;
            end
            step(we, wa, din, re, ra);
            check($sformatf("rand%0d", n), data_out, exp_big);
            check($sformatf("rand%0d_small", n), data_out_small, exp_small);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem2_ram.md
# mem2_ram

Single-clock, simple-dual-port synchronous RAM with one write port and one registered read port. Used as a small scratch buffer in the dot-product datapath (operand/vector storage). Writes and reads are independent and may occur in the same cycle. Read data appears one clock after the read request.

## Interface
- DATA_WIDTH, 8, word width in bits.
- MEM_SIZE, 64, number of storage words; must be ≥ 1.
- ADDR_WIDTH, 4, address width. With the defaults only words 0..15 are reachable.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- write_en  input  1  write strobe, sampled on rising clk.
- write_address  input  ADDR_WIDTH  write word index.
- data_in  input  DATA_WIDTH  write data.
- read_en  input  1  read strobe, sampled on rising clk.
- read_address  input  ADDR_WIDTH  read word index.
- data_out  output  DATA_WIDTH  registered read data.

## Operation
- Storage: MEM_SIZE words of DATA_WIDTH bits. Contents are not cleared by reset and are undefined after power-up.
- Write: on a rising clk with write_en=1, rst=0 and write_address < MEM_SIZE, write data_in to mem[write_address]. A write to address ≥ MEM_SIZE is dropped.
- Read: on a rising clk with read_en=1 and rst=0, load data_out with mem[read_address]. If read_address ≥ MEM_SIZE, load 0.
- read_en=0: data_out holds its previous value.
- Read and write on different addresses in the same cycle: both complete independently.
- Read and write on the same address in the same cycle: default is read-first, so data_out gets the old contents. The Configuration section overrides this.
- No handshake and no back-pressure. Every enabled access completes in its cycle.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable by a read issued at edge N+1 or later.
- Read latency: 1 cycle. A read sampled at edge N shows on data_out right after edge N and stays stable until the next enabled read edge.
- Reset asserted, at any time including mid-access:
  - data_out goes to 0 immediately (asynchronously).
  - Enabled writes and reads are ignored while rst=1.
  - Memory contents are retained.
- First edge after rst deasserts: normal operation.
- Back-to-back reads and writes every cycle are supported at full rate.

## Configuration
- MEM2_WRITE_FIRST_EN defined: a same-cycle, same-address read and write forwards data_in to data_out (write-first). The memory is updated as normal.
- MEM2_WRITE_FIRST_EN undefined: read-first behaviour as described in Operation.
- All other behaviour is identical with or without the macro.

## Structure
- Package mem2_pkg holds:
  - default constants MEM2_DATA_WIDTH=8, MEM2_MEM_SIZE=64, MEM2_ADDR_WIDTH=4;
  - typedefs for mem2_data_t and mem2_addr_t.
- Sub-module mem2_storage: the bare array with the synchronous write port and the combinational read index.
- Top-level mem2 instantiates mem2_storage and adds:
  - address range checks;
  - the data_out register with asynchronous reset;
  - the optional write-first forwarding mux.

## Test plan
- Reset: assert rst with read_en=1 → data_out=0x00 immediately and it stays 0 while rst=1.
- Basic write/read: write 0x11@0, then write 0x22@1; read@0 → data_out=0x11 one cycle later; read@1 → 0x22.
- Overwrite: write 0xA5@1, then read@1 → data_out=0xA5.
- Hold: after reading 0xA5, drop read_en and change read_address to 0 → data_out stays 0xA5.
- Collision: mem[3]=0x5A; in the same cycle write 0xC3@3 and read@3:
  - without MEM2_WRITE_FIRST_EN → data_out=0x5A, and the next read@3 returns 0xC3;
  - with the macro → data_out=0xC3.
- Reset mid-operation: mem[0]=0x11; pulse rst between accesses → data_out=0; after release, read@0 → 0x11 (contents retained).
